// File: rtl/sap_ram.sv
// sap_ram: parametrised synchronous RAM for the SAP computer models.
//
// A clocked, width/depth-generalised successor of the 74189 RAM. It has a
// CPU read/write port, a front-panel programming port that overrides the
// CPU port, an optional inverted output, and a clear sequencer that
// zero-fills the array after reset or on request.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset; restarts the clear sweep
//   i_addr       CPU port address
//   i_din        CPU port write data
//   i_cs_n       CPU port chip select, active low
//   i_we_n       CPU port write enable, active low
//   i_prog_en    programming mode; the CPU port is ignored while high
//   i_prog_addr  programming address
//   i_prog_data  programming write data
//   i_prog_we    programming write strobe, active high
//   i_clr_req    one-cycle pulse that restarts the zero-fill (RUN only)
//   o_dout       registered read data (inverted when INVERT_OUT=1)
//   o_busy       high while the clear sequencer owns the array
module sap_ram #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int INVERT_OUT = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_cs_n,
    input  logic              i_we_n,
    input  logic              i_prog_en,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    input  logic              i_prog_we,
    input  logic              i_clr_req,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    // The output register holds q already inverted when INVERT_OUT=1, so
    // its reset value is the inverse of q's reset value of zero.
    localparam logic [DATA_W-1:0] DOUT_RST  = (INVERT_OUT != 0) ? {DATA_W{1'b1}}
                                                                : {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;
    logic [DATA_W-1:0] r_dout;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_re;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_dout_next;

    // Access arbitration: clear sweep, then programming port, then CPU port.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = {DATA_W{1'b0}};
        w_re    = 1'b0;
        w_raddr = i_addr;
        if (i_rst) begin
            // Reset edge only restarts the sweep; nothing touches the array.
            w_we = 1'b0;
        end else if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_ptr;
            w_wdata = {DATA_W{1'b0}};
        end else if (i_prog_en) begin
            if (i_prog_we) begin
                w_we    = 1'b1;
                w_waddr = i_prog_addr;
                w_wdata = i_prog_data;
            end else begin
                w_re    = 1'b1;
                w_raddr = i_prog_addr;
            end
        end else if (!i_cs_n) begin
            if (!i_we_n) begin
                w_we    = 1'b1;
                w_waddr = i_addr;
                w_wdata = i_din;
            end else begin
                w_re    = 1'b1;
                w_raddr = i_addr;
            end
        end else begin
            w_re = 1'b0;
        end
    end

    // Read mux and optional 74189-style output inversion.
    always_comb begin
        w_rdata = r_mem[w_raddr];
        if (INVERT_OUT != 0) begin
            w_dout_next = ~w_rdata;
        end else begin
            w_dout_next = w_rdata;
        end
    end

    // Storage array write port; contents are cleared by the sweep, not reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Clear/run sequencer, busy flag and registered read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= {ADDR_W{1'b0}};
            r_busy    <= 1'b1;
            r_dout    <= DOUT_RST;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // clr_req is ignored here: the sweep never restarts mid-way.
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b0;
                        r_clr_ptr <= {ADDR_W{1'b0}};
                    end else begin
                        r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (i_clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_ptr <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_busy    <= 1'b1;
                    r_clr_ptr <= {ADDR_W{1'b0}};
                end
            endcase
            if (w_re) begin
                r_dout <= w_dout_next;
            end
        end
    end

    assign o_dout = r_dout;
    assign o_busy = r_busy;

endmodule
